// File: rtl/seq_gen_tx.sv
// Serial pattern transmitter: sends Pat MSB-first Reps times on Out, Moore FSM with debug state on CS.
// Optional inter-repetition idle gap enabled by defining SEQ_GEN_TX_GAP_EN.
module seq_gen_tx #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] Pat,
  input  logic [CNT_W-1:0] Reps,
  input  logic             Abort,
  output logic             Out,
  output logic             Valid,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] Sent,
  output logic [1:0]       CS
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam int              BC_W     = $clog2(WIDTH);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(WIDTH - 1);

  if (WIDTH < 2 || GAP < 1) begin : g_param_check
    $error("seq_gen_tx: WIDTH must be >= 2 and GAP >= 1");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [BC_W-1:0]  bit_cnt;
  logic [CNT_W-1:0] reps_q;
  logic [CNT_W-1:0] sent_q;
  logic             load_start;
  logic             reload;
  logic             last_bit;
  logic             last_rep;
  logic             rep_end;

`ifdef SEQ_GEN_TX_GAP_EN
  localparam int              GC_W     = $clog2(GAP + 1);
  localparam logic [GC_W-1:0] GAP_LAST = GC_W'(GAP - 1);
  logic [GC_W-1:0] gap_cnt;
  logic            gap_end;
  assign gap_end = (gap_cnt == GAP_LAST);
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] reps_norm(input logic [CNT_W-1:0] r);
    return (r == '0) ? CNT_W'(1) : r;
  endfunction

  assign last_bit = (state == S_SEND) && (bit_cnt == BIT_LAST);
  assign last_rep = ((sent_q + CNT_W'(1)) == reps_q);
  // An aborted final bit does not count as a completed repetition.
  assign rep_end  = last_bit && !Abort;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_start = 1'b0;
    reload     = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start && !Abort) begin
          state_nxt  = S_SEND;
          load_start = 1'b1;
        end
      end
      S_SEND: begin
        if (Abort) begin
          state_nxt = S_IDLE;
        end else if (last_bit) begin
          if (last_rep) begin
            state_nxt = S_FIN;
          end else begin
`ifdef SEQ_GEN_TX_GAP_EN
            state_nxt = S_GAP;
`else
            reload    = 1'b1;
`endif
          end
        end
      end
      S_GAP: begin
`ifdef SEQ_GEN_TX_GAP_EN
        if (Abort) begin
          state_nxt = S_IDLE;
        end else if (gap_end) begin
          state_nxt = S_SEND;
          reload    = 1'b1;
        end
`else
        state_nxt = S_IDLE;
`endif
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      reps_q  <= '0;
      sent_q  <= '0;
    end else begin
      if (load_start) begin
        shreg   <= Pat;
        reps_q  <= reps_norm(Reps);
        bit_cnt <= '0;
        sent_q  <= '0;
      end else if (reload) begin
        shreg   <= Pat;
        bit_cnt <= '0;
      end else if (state == S_SEND) begin
        shreg   <= shreg << 1;
        bit_cnt <= last_bit ? '0 : bit_cnt + BC_W'(1);
      end
      if (rep_end) sent_q <= sat_inc(sent_q);
    end
  end

`ifdef SEQ_GEN_TX_GAP_EN
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)                gap_cnt <= '0;
    else if (state == S_GAP) gap_cnt <= gap_end ? '0 : gap_cnt + GC_W'(1);
    else                     gap_cnt <= '0;
  end
`endif

  assign Valid = (state == S_SEND);
  assign Out   = Valid & shreg[WIDTH-1];
  assign Busy  = (state != S_IDLE);
  assign Done  = (state == S_FIN);
  assign Sent  = sent_q;
  assign CS    = state;

endmodule

// File: tb/tb_seq_gen_tx.sv
// Bench for seq_gen_tx: per-cycle expected-stream model plus directed literal checks.
module tb_seq_gen_tx;
  localparam int WIDTH = 4;
  localparam int CNT_W = 4;
  localparam int GAP   = 2;
`ifdef SEQ_GEN_TX_GAP_EN
  localparam int G = GAP;
`else
  localparam int G = 0;
`endif

  logic             Clk = 1'b0;
  logic             Rst;
  logic             Start;
  logic [WIDTH-1:0] Pat;
  logic [CNT_W-1:0] Reps;
  logic             Abort;
  logic             Out;
  logic             Valid;
  logic             Busy;
  logic             Done;
  logic [CNT_W-1:0] Sent;
  logic [1:0]       CS;

  seq_gen_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP(GAP)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Pat(Pat), .Reps(Reps), .Abort(Abort),
    .Out(Out), .Valid(Valid), .Busy(Busy), .Done(Done), .Sent(Sent), .CS(CS)
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Expected outputs for one cycle of a transmission; a queue holds the whole remaining stream.
  typedef struct packed {
    logic             out;
    logic             vld;
    logic             done;
    logic [CNT_W-1:0] sent;
    logic [1:0]       cs;
  } exp_t;

  exp_t             q[$];
  logic [CNT_W-1:0] m_sent = '0;

  function automatic exp_t mk(input logic o, input logic v, input logic d,
                              input int s, input logic [1:0] c);
    exp_t e;
    e.out  = o;
    e.vld  = v;
    e.done = d;
    e.sent = CNT_W'(s);
    e.cs   = c;
    return e;
  endfunction

  task automatic build(input logic [WIDTH-1:0] p, input logic [CNT_W-1:0] r);
    int rn;
    rn = (r == '0) ? 1 : int'(r);
    for (int k = 0; k < rn; k++) begin
      for (int b = WIDTH - 1; b >= 0; b--) q.push_back(mk(p[b], 1'b1, 1'b0, k, 2'd1));
      if (k < rn - 1)
        for (int g = 0; g < G; g++) q.push_back(mk(1'b0, 1'b0, 1'b0, k + 1, 2'd2));
    end
    q.push_back(mk(1'b0, 1'b0, 1'b1, rn, 2'd3));
  endtask

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      q.delete();
      m_sent <= '0;
    end else if (q.size() > 0) begin
      m_sent <= q[0].sent;
      if (Abort) q.delete();
      else       void'(q.pop_front());
    end else if (Start && !Abort) begin
      build(Pat, Reps);
    end
  end

  always @(negedge Clk) begin : mon
    exp_t e;
    e = (q.size() > 0) ? q[0] : mk(1'b0, 1'b0, 1'b0, int'(m_sent), 2'd0);
    chk("cycle{out,vld,done,sent,cs}", 32'({Out, Valid, Done, Sent, CS}), 32'(e));
    chk("busy", 32'(Busy), 32'(q.size() > 0));
  end

  logic [31:0] vo, vv, vd, vb;

  // Pulse Start at edge 0, then record cycles 1..n; optional Start/Abort pulses in given cycles.
  task automatic xmit(input int n, input int st_at, input int ab_at);
    vo = '0; vv = '0; vd = '0; vb = '0;
    Start = 1'b1;
    @(posedge Clk); #1;
    for (int i = 1; i <= n; i++) begin
      Start = (i == st_at);
      Abort = (i == ab_at);
      vo = {vo[30:0], Out};
      vv = {vv[30:0], Valid};
      vd = {vd[30:0], Done};
      vb = {vb[30:0], Busy};
      @(posedge Clk); #1;
    end
    Start = 1'b0;
    Abort = 1'b0;
  endtask

  initial begin
    Rst = 1'b0; Start = 1'b0; Abort = 1'b0; Pat = '0; Reps = '0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_out", 32'(Out), 32'd0);
    chk("rst_valid", 32'(Valid), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_sent", 32'(Sent), 32'd0);
    chk("rst_cs", 32'(CS), 32'd0);
    Rst = 1'b1;
    @(posedge Clk); #1;

    Pat = 4'b1010; Reps = 4'd1;
    xmit(6, 0, 0);
    chk("t1_out", vo, 32'b101000);
    chk("t1_valid", vv, 32'b111100);
    chk("t1_done", vd, 32'b000010);
    chk("t1_busy", vb, 32'b111110);
    chk("t1_sent", 32'(Sent), 32'd1);

    Pat = 4'b1010; Reps = 4'd2;
`ifdef SEQ_GEN_TX_GAP_EN
    xmit(12, 0, 0);
    chk("t2_out", vo, 32'b101000101000);
    chk("t2_valid", vv, 32'b111100111100);
    chk("t2_done", vd, 32'b000000000010);
    chk("t2_busy", vb, 32'b111111111110);
`else
    xmit(10, 0, 0);
    chk("t2_out", vo, 32'b1010101000);
    chk("t2_valid", vv, 32'b1111111100);
    chk("t2_done", vd, 32'b0000000010);
    chk("t2_busy", vb, 32'b1111111110);
`endif
    chk("t2_sent", 32'(Sent), 32'd2);

    Pat = 4'b1100; Reps = 4'd0;
    xmit(8, 2, 0);
    chk("t3_out", vo, 32'b11000000);
    chk("t3_valid", vv, 32'b11110000);
    chk("t3_done", vd, 32'b00001000);
    chk("t3_busy", vb, 32'b11111000);
    chk("t3_sent", 32'(Sent), 32'd1);

    Pat = 4'b1010; Reps = 4'd3;
    xmit(8, 0, 6);
`ifdef SEQ_GEN_TX_GAP_EN
    chk("t4_out", vo, 32'b10100000);
    chk("t4_valid", vv, 32'b11110000);
`else
    chk("t4_out", vo, 32'b10101000);
    chk("t4_valid", vv, 32'b11111100);
`endif
    chk("t4_busy", vb, 32'b11111100);
    chk("t4_done", vd, 32'b00000000);
    chk("t4_sent", 32'(Sent), 32'd1);
    Start = 1'b1; Abort = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0; Abort = 1'b0;
    chk("t4_sa_cs", 32'(CS), 32'd0);
    chk("t4_sa_busy", 32'(Busy), 32'd0);
    chk("t4_sa_sent", 32'(Sent), 32'd1);
    @(posedge Clk); #1;

    Pat = 4'b1010; Reps = 4'd2;
    xmit(2, 0, 0);
    chk("t5_pre_busy", 32'(Busy), 32'd1);
    Rst = 1'b0;
    #1;
    chk("t5_rst_out", 32'(Out), 32'd0);
    chk("t5_rst_valid", 32'(Valid), 32'd0);
    chk("t5_rst_busy", 32'(Busy), 32'd0);
    chk("t5_rst_done", 32'(Done), 32'd0);
    chk("t5_rst_sent", 32'(Sent), 32'd0);
    chk("t5_rst_cs", 32'(CS), 32'd0);
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk); #1;
    Pat = 4'b0110; Reps = 4'd1;
    xmit(6, 0, 0);
    chk("t5_out", vo, 32'b011000);
    chk("t5_valid", vv, 32'b111100);
    chk("t5_done", vd, 32'b000010);
    chk("t5_sent", 32'(Sent), 32'd1);

    repeat (2) @(posedge Clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
